// File: rtl/basys_input_port.sv
// Memory-mapped input peripheral for the Basys board: synchronized switches,
// debounced push-buttons, sticky press events and a press counter on the data bus.
module basys_input_port #(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FF00,
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter int          NBTN            = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     sw,
    input  logic [NBTN-1:0] btn,
    input  logic [31:0]     DataAdr,
    input  logic [31:0]     WriteData,
    input  logic            MemWriteM,
    output logic [31:0]     ReadData,
    output logic            Hit
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [15:0]     sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [NBTN-1:0] btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
    logic [NBTN-1:0] btn_stable_q, btn_stable_d;
    logic [NBTN-1:0] evt_q, evt_d;
    logic [15:0]     press_cnt_q, press_cnt_d;
    logic [CW-1:0]   cnt_q [NBTN];
    logic [CW-1:0]   cnt_d [NBTN];

    logic [NBTN-1:0] rise;
    logic [15:0]     rise_count;
    logic            hit;
    logic            wr_evt;
    logic            wr_cnt;
    logic            unused_bits;

    always_comb begin
        sw_meta_d    = sw;
        sw_sync_d    = sw_meta_q;
        btn_meta_d   = btn;
        btn_sync_d   = btn_meta_q;
        btn_stable_d = btn_stable_q;
        rise         = '0;
        // A level is accepted only after it has differed from the stable value
        // for DEBOUNCE_CYCLES consecutive edges; any return resets the run.
        for (int i = 0; i < NBTN; i++) begin
            cnt_d[i] = '0;
            if (btn_sync_q[i] != btn_stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    btn_stable_d[i] = btn_sync_q[i];
                    rise[i]         = btn_sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        rise_count = '0;
        for (int i = 0; i < NBTN; i++) begin
            rise_count = rise_count + 16'(rise[i]);
        end
    end

    always_comb begin
        hit    = (DataAdr[31:4] == BASE_ADDR[31:4]);
        wr_evt = MemWriteM && hit && (DataAdr[3:2] == 2'b10);
        wr_cnt = MemWriteM && hit && (DataAdr[3:2] == 2'b11);

        // New events are OR-ed in after the clear so a same-edge press survives.
        evt_d = evt_q;
        if (wr_evt) begin
            evt_d = evt_q & ~WriteData[NBTN-1:0];
        end
        evt_d = evt_d | rise;

        press_cnt_d = (wr_cnt ? 16'h0 : press_cnt_q) + rise_count;
    end

    always_comb begin
        case (DataAdr[3:2])
            2'b00:   ReadData = {16'h0, sw_sync_q};
            2'b01:   ReadData = 32'(btn_stable_q);
            2'b10:   ReadData = 32'(evt_q);
            default: ReadData = {16'h0, press_cnt_q};
        endcase
        Hit = hit;
    end

    assign unused_bits = ^{DataAdr[1:0], WriteData[31:NBTN]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            btn_meta_q   <= '0;
            btn_sync_q   <= '0;
            btn_stable_q <= '0;
            evt_q        <= '0;
            press_cnt_q  <= '0;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sw_meta_q    <= sw_meta_d;
            sw_sync_q    <= sw_sync_d;
            btn_meta_q   <= btn_meta_d;
            btn_sync_q   <= btn_sync_d;
            btn_stable_q <= btn_stable_d;
            evt_q        <= evt_d;
            press_cnt_q  <= press_cnt_d;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_basys_input_port.sv
// Bench for basys_input_port: directed scenarios plus random traffic checked
// against a sample-history reference model; a second instance covers counter wrap.
module tb_basys_input_port;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam int          DB   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic [4:0]  btn;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        MemWriteM;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] ReadData2;
    logic        Hit2;

    int total = 0;
    int bad   = 0;

    basys_input_port #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(DB), .NBTN(5)) dut (
        .clk(clk), .rst(rst), .sw(sw), .btn(btn), .DataAdr(DataAdr),
        .WriteData(WriteData), .MemWriteM(MemWriteM), .ReadData(ReadData), .Hit(Hit)
    );

    basys_input_port #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(2), .NBTN(5)) dut2 (
        .clk(clk), .rst(rst), .sw(sw), .btn(btn), .DataAdr(DataAdr),
        .WriteData(WriteData), .MemWriteM(MemWriteM), .ReadData(ReadData2), .Hit(Hit2)
    );

    always #5 clk = ~clk;

    // Reference model: pin samples travel through a two-deep queue; a button
    // flips once its last DB synchronized samples all disagree with it.
    logic [15:0] swQ[$];
    logic [4:0]  btnQ[$];
    logic [15:0] mHist [5];
    logic [15:0] mSw;
    logic [4:0]  mStable;
    logic [4:0]  mEvt;
    logic [15:0] mCnt;

    task automatic modelEdge(input logic r, input logic [15:0] s, input logic [4:0] b,
                             input logic [31:0] a, input logic [31:0] wd, input logic we);
        logic [4:0]  used;
        logic [4:0]  riseV;
        logic [15:0] mask;
        logic [15:0] win;
        logic        tgt;
        logic        hitV;
        if (r) begin
            swQ.delete();  swQ.push_back(16'h0);  swQ.push_back(16'h0);
            btnQ.delete(); btnQ.push_back(5'h0);  btnQ.push_back(5'h0);
            for (int i = 0; i < 5; i++) mHist[i] = 16'h0;
            mSw = 16'h0; mStable = 5'h0; mEvt = 5'h0; mCnt = 16'h0;
        end else begin
            used = btnQ[0];
            swQ.push_back(s);  void'(swQ.pop_front());
            btnQ.push_back(b); void'(btnQ.pop_front());
            mSw   = swQ[0];
            mask  = (16'h1 << DB) - 16'h1;
            riseV = 5'h0;
            for (int i = 0; i < 5; i++) begin
                mHist[i] = {mHist[i][14:0], used[i]};
                win = mHist[i] & mask;
                tgt = ~mStable[i];
                if (tgt ? (win == mask) : (win == 16'h0)) begin
                    mStable[i] = tgt;
                    riseV[i]   = tgt;
                end
            end
            hitV = (a[31:4] == BASE[31:4]);
            if (we && hitV && a[3:2] == 2'd2) mEvt = mEvt & ~wd[4:0];
            mEvt = mEvt | riseV;
            if (we && hitV && a[3:2] == 2'd3) mCnt = 16'h0;
            mCnt = mCnt + 16'($countones(riseV));
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        case (a[3:2])
            2'd0:    return {16'h0, mSw};
            2'd1:    return {27'h0, mStable};
            2'd2:    return {27'h0, mEvt};
            default: return {16'h0, mCnt};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [15:0] s, input logic [4:0] b,
                                 input logic [31:0] a, input logic [31:0] wd, input logic we);
        rst = r; sw = s; btn = b; DataAdr = a; WriteData = wd; MemWriteM = we;
        @(posedge clk);
        modelEdge(r, s, b, a, wd, we);
        #1;
        checkOutput("rdata", ReadData, modelRead(a));
        checkOutput("hit", {31'h0, Hit}, {31'h0, a[31:4] == BASE[31:4]});
    endtask

    task automatic peekCheck(input string tag, input logic [31:0] a, input logic [31:0] exp);
        MemWriteM = 1'b0;
        DataAdr   = a;
        #1;
        checkOutput(tag, ReadData, exp);
    endtask

    initial begin
        logic [4:0]  b;
        logic [31:0] a;
        logic        r;

        // Reset with everything asserted on the pins.
        applyStimulus(1'b1, 16'hFFFF, 5'h1F, BASE, 32'h0, 1'b0);
        applyStimulus(1'b1, 16'hFFFF, 5'h1F, BASE, 32'h0, 1'b0);
        peekCheck("rst_sw",  BASE + 32'h0, 32'h0);
        peekCheck("rst_btn", BASE + 32'h4, 32'h0);
        peekCheck("rst_evt", BASE + 32'h8, 32'h0);
        peekCheck("rst_cnt", BASE + 32'hC, 32'h0);
        applyStimulus(1'b0, 16'hFFFF, 5'h0, BASE, 32'h0, 1'b0);
        checkOutput("sw_lat1", ReadData, 32'h0);
        applyStimulus(1'b0, 16'hFFFF, 5'h0, BASE, 32'h0, 1'b0);
        checkOutput("sw_lat2", ReadData, 32'h0000_FFFF);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 16'hFFFF, 5'h0, BASE, 32'h0, 1'b0);

        // Clean press and release of btn[2].
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b0, 16'hFFFF, 5'b00100, BASE + 32'h4, 32'h0, 1'b0);
            checkOutput("press_btn", ReadData, (k == 6) ? 32'h4 : 32'h0);
        end
        peekCheck("press_evt", BASE + 32'h8, 32'h4);
        peekCheck("press_cnt", BASE + 32'hC, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b0, 16'hFFFF, 5'b00000, BASE + 32'h4, 32'h0, 1'b0);
            checkOutput("release_btn", ReadData, (k == 6) ? 32'h0 : 32'h4);
        end
        peekCheck("release_evt", BASE + 32'h8, 32'h4);

        // Bouncing btn[0] before it settles high.
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b0, 16'hFFFF, (k % 2 == 0) ? 5'b00001 : 5'b00000, BASE + 32'h4, 32'h0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b0, 16'hFFFF, 5'b00001, BASE + 32'h4, 32'h0, 1'b0);
            checkOutput("bounce_btn", ReadData, (k == 6) ? 32'h1 : 32'h0);
        end
        peekCheck("bounce_evt", BASE + 32'h8, 32'h5);
        peekCheck("bounce_cnt", BASE + 32'hC, 32'h2);

        // Write-1-to-clear, then a clear racing a re-accepted press on btn[4].
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 16'h1234, 5'b10001, BASE, 32'h0, 1'b0);
        peekCheck("w1c_pre", BASE + 32'h8, 32'h15);
        applyStimulus(1'b0, 16'h1234, 5'b10001, BASE + 32'h8, 32'h5, 1'b1);
        peekCheck("w1c_post", BASE + 32'h8, 32'h10);
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 16'h1234, 5'b00001, BASE, 32'h0, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 16'h1234, 5'b10001, BASE, 32'h0, 1'b0);
        applyStimulus(1'b0, 16'h1234, 5'b10001, BASE + 32'h8, 32'h10, 1'b1);
        peekCheck("race_evt", BASE + 32'h8, 32'h10);
        peekCheck("race_cnt", BASE + 32'hC, 32'h4);

        // Address decode: just outside the window, and an unaligned inside address.
        applyStimulus(1'b0, 16'h1234, 5'b10001, BASE + 32'h10, 32'h1F, 1'b1);
        checkOutput("miss_hit", {31'h0, Hit}, 32'h0);
        applyStimulus(1'b0, 16'h1234, 5'b10001, BASE + 32'h1C, 32'hFFFF_FFFF, 1'b1);
        peekCheck("miss_evt", BASE + 32'h8, 32'h10);
        peekCheck("miss_cnt", BASE + 32'hC, 32'h4);
        DataAdr = BASE + 32'h7;
        #1;
        checkOutput("unal_hit", {31'h0, Hit}, 32'h1);
        checkOutput("unal_btn", ReadData, 32'h11);

        // Random traffic with slowly changing buttons and occasional resets.
        b = 5'b10001;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 5; i++) if ($urandom_range(7) == 0) b[i] = ~b[i];
            case ($urandom_range(3))
                0:       a = BASE + 32'($urandom_range(15));
                1:       a = BASE + 32'h8;
                2:       a = BASE + 32'hC;
                default: a = $urandom;
            endcase
            r = ($urandom_range(399) == 0);
            applyStimulus(r, 16'($urandom), b, a,
                          ($urandom_range(1) == 0) ? 32'($urandom_range(31)) : $urandom,
                          ($urandom_range(3) == 0));
        end

        // Counter wrap on the short-debounce instance: 65537 accepted presses.
        applyStimulus(1'b1, 16'h0, 5'h0, BASE + 32'hC, 32'h0, 1'b0);
        applyStimulus(1'b1, 16'h0, 5'h0, BASE + 32'hC, 32'h0, 1'b0);
        for (int n = 0; n < 13107; n++) begin
            applyStimulus(1'b0, 16'h0, 5'h1F, BASE + 32'hC, 32'h0, 1'b0);
            applyStimulus(1'b0, 16'h0, 5'h1F, BASE + 32'hC, 32'h0, 1'b0);
            applyStimulus(1'b0, 16'h0, 5'h00, BASE + 32'hC, 32'h0, 1'b0);
            applyStimulus(1'b0, 16'h0, 5'h00, BASE + 32'hC, 32'h0, 1'b0);
        end
        applyStimulus(1'b0, 16'h0, 5'h03, BASE + 32'hC, 32'h0, 1'b0);
        applyStimulus(1'b0, 16'h0, 5'h03, BASE + 32'hC, 32'h0, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 16'h0, 5'h00, BASE + 32'hC, 32'h0, 1'b0);
        checkOutput("cnt_wrap", ReadData2, 32'h1);
        checkOutput("hit2", {31'h0, Hit2}, 32'h1);
        applyStimulus(1'b0, 16'h0, 5'h00, BASE + 32'hC, 32'h0, 1'b1);
        checkOutput("cnt_clear", ReadData2, 32'h0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 16'h0, 5'h03, BASE + 32'hC, 32'h0, 1'b0);
        checkOutput("cnt_dual", ReadData2, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
